ibu_pipe: RTL and testbench

Pipelined inverse (Gentleman–Sande) butterfly for the Dilithium INTT datapath, modulus q = 8380417. It is the inverse-direction counterpart of the forward NTT butterfly. Per accepted operand set it computes A = (X + Y) mod q and B = ((X − Y) · TF) mod q. It sits between the INTT coefficient memory read port and the write-back path, with a valid/ready handshake on both sides and full throughput of one butterfly per cycle.

---
 rtl/ntt_pkg.sv | 34 +++
 rtl/mod_reduce46.sv | 25 ++
 rtl/ibu_pipe.sv | 83 ++++++++
 tb/tb_ibu_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT/INTT constants and modular helpers for the Dilithium datapath (q = 8380417).
// Used by the forward and inverse butterflies and by mod_reduce46.
package ntt_pkg;

    localparam int unsigned COEFF_W = 23;
    localparam int unsigned PROD_W  = 46;
    localparam logic [COEFF_W-1:0] Q = 23'd8380417;

    function automatic logic [COEFF_W-1:0] mod_add(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] b);
        logic [COEFF_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, Q})
            sum = sum - {1'b0, Q};
        return sum[COEFF_W-1:0];
    endfunction

    function automatic logic [COEFF_W-1:0] mod_sub(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] b);
        logic [COEFF_W:0] diff;
        // Wraps modulo 2^24 when a < b; adding q restores the true residue.
        diff = {1'b0, a} - {1'b0, b};
        if (a < b)
            diff = diff + {1'b0, Q};
        return diff[COEFF_W-1:0];
    endfunction

    function automatic logic [COEFF_W-1:0] halve_mod(input logic [COEFF_W-1:0] x);
        logic [COEFF_W:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, Q}) : {1'b0, x};
        return t[COEFF_W:1];
    endfunction

endpackage

// File: rtl/mod_reduce46.sv
// Combinational reduction of a 46-bit product to [0, q) using 2^23 = 2^13 - 1 (mod q).
// Three folds bring the value below 2q; one conditional subtract finishes it.
module mod_reduce46
    import ntt_pkg::*;
(
    input  logic [PROD_W-1:0]  p,
    output logic [COEFF_W-1:0] r
);

    logic [36:0] r1;
    logic [27:0] r2;
    logic [23:0] r3;

    // Each fold is lo + hi*(2^13 - 1); hi*8191 is never negative, so no underflow.
    always_comb begin
        r1 = 37'(p[22:0]) + (37'(p[45:23]) << 13) - 37'(p[45:23]);
        r2 = 28'(r1[22:0]) + (28'(r1[36:23]) << 13) - 28'(r1[36:23]);
        r3 = 24'(r2[22:0]) + (24'(r2[27:23]) << 13) - 24'(r2[27:23]);
        if (r3 >= {1'b0, Q})
            r = 23'(r3 - {1'b0, Q});
        else
            r = r3[COEFF_W-1:0];
    end

endmodule

// File: rtl/ibu_pipe.sv
// Three-stage Gentleman-Sande inverse butterfly: A = X+Y, B = (X-Y)*TF mod q, valid/ready on both sides.
// Define IBU_HALVE_EN to fold the per-layer 1/2 INTT scaling into stage 1.
module ibu_pipe
    import ntt_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] X,
    input  logic [COEFF_W-1:0] Y,
    input  logic [COEFF_W-1:0] TF,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COEFF_W-1:0] A,
    output logic [COEFF_W-1:0] B
);

    logic               v1, v2, v3;
    logic               adv1, adv2, adv3;
    logic [COEFF_W-1:0] s1, d1, tf1, s2, a3, b3;
    logic [PROD_W-1:0]  p2;
    logic [COEFF_W-1:0] s_in, d_in, b_red;

    always_comb begin
        adv3     = out_ready || !v3;
        adv2     = adv3 || !v2;
        adv1     = adv2 || !v1;
        in_ready = adv1;
    end

    always_comb begin
`ifdef IBU_HALVE_EN
        s_in = halve_mod(mod_add(X, Y));
        d_in = halve_mod(mod_sub(X, Y));
`else
        s_in = mod_add(X, Y);
        d_in = mod_sub(X, Y);
`endif
    end

    mod_reduce46 u_reduce (
        .p (p2),
        .r (b_red)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            s1  <= '0;
            d1  <= '0;
            tf1 <= '0;
            s2  <= '0;
            p2  <= '0;
            a3  <= '0;
            b3  <= '0;
        end else begin
            if (adv1) begin
                v1  <= in_valid;
                s1  <= s_in;
                d1  <= d_in;
                tf1 <= TF;
            end
            if (adv2) begin
                v2 <= v1;
                s2 <= s1;
                p2 <= {23'b0, d1} * {23'b0, tf1};
            end
            if (adv3) begin
                v3 <= v2;
                a3 <= s2;
                b3 <= b_red;
            end
        end
    end

    assign out_valid = v3;
    assign A         = a3;
    assign B         = b3;

endmodule

// File: tb/tb_ibu_pipe.sv
// Self-checking bench for ibu_pipe: directed table, randomized stream vs. arithmetic model, reset flush.
// Honors IBU_HALVE_EN in the same way as the design.
module tb_ibu_pipe;

    localparam longint unsigned QL   = 64'd8380417;
    localparam longint unsigned INV2 = 64'd4190209;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] X, Y, TF;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] A, B;

    int unsigned checks = 0;
    int unsigned errors = 0;

    ibu_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .TF        (TF),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic; halving is multiplication by 2^-1 mod q.
    function automatic longint unsigned ref_a(input longint unsigned x, input longint unsigned y);
        longint unsigned r;
        r = (x + y) % QL;
`ifdef IBU_HALVE_EN
        r = (r * INV2) % QL;
`endif
        return r;
    endfunction

    function automatic longint unsigned ref_b(input longint unsigned x, input longint unsigned y,
                                              input longint unsigned t);
        longint unsigned r;
        r = (((x + QL - y) % QL) * t) % QL;
`ifdef IBU_HALVE_EN
        r = (r * INV2) % QL;
`endif
        return r;
    endfunction

    typedef struct {
        logic [22:0] x, y, tf;
        logic [22:0] a, b;
    } vec_t;

    vec_t vecs[6];

    longint unsigned exp_q[$];
    longint unsigned e;
    logic            prev_stall;
    logic [22:0]     prev_a, prev_b;
    int unsigned     accepted;
    int unsigned     cycles;
    logic            acc, emit;

    initial begin
`ifdef IBU_HALVE_EN
        vecs[0] = '{x: 23'd5,       y: 23'd3,       tf: 23'd1,       a: 23'd4,       b: 23'd1};
        vecs[1] = '{x: 23'd3,       y: 23'd5,       tf: 23'd1,       a: 23'd4,       b: 23'd8380416};
        vecs[2] = '{x: 23'd8380416, y: 23'd8380416, tf: 23'd8380416, a: 23'd8380416, b: 23'd0};
        vecs[3] = '{x: 23'd8380416, y: 23'd0,       tf: 23'd8380416, a: 23'd4190208, b: 23'd4190209};
        vecs[4] = '{x: 23'd1,       y: 23'd0,       tf: 23'd8380416, a: 23'd4190209, b: 23'd4190208};
        vecs[5] = '{x: 23'd0,       y: 23'd0,       tf: 23'd0,       a: 23'd0,       b: 23'd0};
`else
        vecs[0] = '{x: 23'd5,       y: 23'd3,       tf: 23'd1,       a: 23'd8,       b: 23'd2};
        vecs[1] = '{x: 23'd3,       y: 23'd5,       tf: 23'd1,       a: 23'd8,       b: 23'd8380415};
        vecs[2] = '{x: 23'd8380416, y: 23'd8380416, tf: 23'd8380416, a: 23'd8380415, b: 23'd0};
        vecs[3] = '{x: 23'd8380416, y: 23'd0,       tf: 23'd8380416, a: 23'd8380416, b: 23'd1};
        vecs[4] = '{x: 23'd1,       y: 23'd0,       tf: 23'd8380416, a: 23'd1,       b: 23'd8380416};
        vecs[5] = '{x: 23'd0,       y: 23'd0,       tf: 23'd0,       a: 23'd0,       b: 23'd0};
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        X = '0; Y = '0; TF = '0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_A", A, 0);
        check("reset_B", B, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors, one at a time, with latency check
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            X = vecs[i].x; Y = vecs[i].y; TF = vecs[i].tf;
            #1 check("dir_in_ready", in_ready, 1);
            @(posedge clk);
            @(negedge clk) in_valid = 1'b0;
            check("dir_lat1", out_valid, 0);
            @(negedge clk);
            check("dir_lat2", out_valid, 0);
            @(negedge clk);
            check("dir_lat3", out_valid, 1);
            check("dir_A", A, vecs[i].a);
            check("dir_B", B, vecs[i].b);
            // model agrees with the table too
            check("dir_model_A", ref_a(vecs[i].x, vecs[i].y), vecs[i].a);
            check("dir_model_B", ref_b(vecs[i].x, vecs[i].y, vecs[i].tf), vecs[i].b);
            @(negedge clk);
            check("dir_drain", out_valid, 0);
        end

        // Randomized stream with random back-pressure
        accepted = 0; cycles = 0; prev_stall = 1'b0; prev_a = '0; prev_b = '0;
        while ((accepted < 1000 || exp_q.size() != 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            in_valid  = (accepted < 1000) && ($urandom_range(3, 0) != 0);
            out_ready = (accepted >= 1000) ? 1'b1 : ($urandom_range(1, 0) == 1);
            case ($urandom_range(7, 0))
                0: begin X = 23'd8380416; Y = 23'd0; TF = 23'd8380416; end
                1: begin X = 23'd0; Y = 23'd8380416; TF = 23'($urandom_range(8380416, 0)); end
                default: begin
                    X  = 23'($urandom_range(8380416, 0));
                    Y  = 23'($urandom_range(8380416, 0));
                    TF = 23'($urandom_range(8380416, 0));
                end
            endcase
            #1;
            if (exp_q.size() == 3 && !out_ready)
                check("rnd_in_ready", in_ready, 0);
            else
                check("rnd_in_ready", in_ready, 1);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_A", A, prev_a);
                check("stall_B", B, prev_b);
            end
            if (out_valid && exp_q.size() == 0)
                check("spurious_out", out_valid, 0);
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (emit && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rnd_A", A, e >> 23);
                check("rnd_B", B, e & 64'h7FFFFF);
            end
            if (acc) begin
                exp_q.push_back((ref_a(X, Y) << 23) | ref_b(X, Y, TF));
                accepted++;
            end
            prev_stall = out_valid && !out_ready;
            prev_a = A; prev_b = B;
        end
        check("rnd_accepted", accepted, 1000);
        check("rnd_drained", exp_q.size(), 0);

        // Fill pipeline under back-pressure, then reset mid-stream
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0;
        X = 23'd7; Y = 23'd2; TF = 23'd9;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("post_rst_quiet", out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
